ecg_frame_scheduler: RTL and testbench

//  Top-level sequencer for the ECG processing datapath. Runs one frame at a time through three phases:

---
 rtl/ecg_frame_scheduler.sv | 144 ++++++++++++++
 tb/tb_ecg_frame_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ecg_frame_scheduler.sv
// ecg_frame_scheduler: frame sequencer for the ECG datapath.
// Walks one frame through LOAD (sample capture), FILT (stage-by-stage
// filter walk) and FETCH (result readout), then pulses frame_done.
// Optional feature macro: ECG_SCHED_CONTINUOUS_EN -- when defined, DONE
// re-enters LOAD directly so frames run back-to-back without start.
module ecg_frame_scheduler #(
  parameter int ADDR_W    = 12,
  parameter int FRAME_LEN = 4096,
  parameter int STAGES    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  output logic [2:0]        stage_sel,
  output logic              stage_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FILT  = 3'd2,
    S_FETCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [2:0]        LAST_STG  = 3'(STAGES - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addra_q, addra_nx;
  logic [ADDR_W-1:0] rd_q, rd_nx;
  logic [2:0]        stg_q, stg_nx;
  logic              ovr_q, ovr_nx;

  // State and counter registers; reset returns everything to a quiet IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addra_q <= '0;
      rd_q    <= '0;
      stg_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      addra_q <= addra_nx;
      rd_q    <= rd_nx;
      stg_q   <= stg_nx;
      ovr_q   <= ovr_nx;
    end
  end

  // Next-state / counter update and strobe decode from the registered state.
  always_comb begin
    state_nx   = state;
    addra_nx   = addra_q;
    rd_nx      = rd_q;
    stg_nx     = stg_q;
    ovr_nx     = ovr_q;
    in_ready   = (state == S_LOAD);
    stage_en   = (state == S_FILT);
    rd_valid   = (state == S_FETCH);
    frame_done = (state == S_DONE);
    busy       = (state != S_IDLE);
    wr_en      = in_valid & in_ready;

    case (state)
      S_IDLE: begin
        // Only an accepted start clears the sticky overrun flag.
        if (start) begin
          state_nx = S_LOAD;
          addra_nx = '0;
          ovr_nx   = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (addra_q == LAST_ADDR) begin
            state_nx = S_FILT;
            addra_nx = '0;
            stg_nx   = '0;
          end else begin
            addra_nx = addra_q + 1'b1;
          end
        end
      end
      S_FILT: begin
        // Inner loop over stages, outer loop over samples.
        if (stg_q == LAST_STG) begin
          stg_nx = '0;
          if (addra_q == LAST_ADDR) begin
            state_nx = S_FETCH;
            addra_nx = '0;
            rd_nx    = '0;
          end else begin
            addra_nx = addra_q + 1'b1;
          end
        end else begin
          stg_nx = stg_q + 1'b1;
        end
      end
      S_FETCH: begin
        if (rd_ready) begin
          if (rd_q == LAST_ADDR) begin
            state_nx = S_DONE;
            rd_nx    = '0;
          end else begin
            rd_nx = rd_q + 1'b1;
          end
        end
      end
      S_DONE: begin
`ifdef ECG_SCHED_CONTINUOUS_EN
        state_nx = S_LOAD;
        addra_nx = '0;
`else
        state_nx = S_IDLE;
`endif
      end
      default: state_nx = S_IDLE;
    endcase

    // A sample arriving while the sample BRAM is not being loaded is lost.
    if (busy && (state != S_LOAD) && in_valid)
      ovr_nx = 1'b1;
  end

  assign addra     = addra_q;
  assign addrb     = (addra_q == '0) ? '0 : addra_q - 1'b1;
  assign stage_sel = stg_q;
  assign rd_addr   = rd_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_ecg_frame_scheduler.sv
// tb_ecg_frame_scheduler: directed bench, FRAME_LEN=8, STAGES=3, ADDR_W=4.
module tb_ecg_frame_scheduler;
  localparam int AW = 4;
  localparam int FL = 8;
  localparam int ST = 3;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, rd_ready;
  logic          in_ready, wr_en, stage_en, rd_valid, busy, frame_done, overrun;
  logic [AW-1:0] addra, addrb, rd_addr;
  logic [2:0]    stage_sel;

  int checks = 0;
  int errors = 0;

  ecg_frame_scheduler #(.ADDR_W(AW), .FRAME_LEN(FL), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .addra(addra), .addrb(addrb),
    .stage_sel(stage_sel), .stage_en(stage_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, checks 1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame();
    for (int i = 0; i < FL; i++) begin
      in_valid = 1'b1;
      #1;
      chk("ld_wr_en", wr_en, 1);
      chk("ld_addra", addra, i);
      chk("ld_addrb", addrb, (i == 0) ? 0 : i - 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    int hs;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_addra", addra, 0);
    chk("rst_stage_sel", stage_sel, 0);
    chk("rst_strobes", {in_ready, stage_en, rd_valid, frame_done, wr_en}, 0);
    chk("rst_overrun", overrun, 0);

    // Frame 1: load, filter (with an overrun), fetch with rd_ready toggling.
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("load_in_ready", in_ready, 1);
    chk("load_busy", busy, 1);
    load_frame();
    chk("filt_entry_stage_en", stage_en, 1);
    chk("filt_entry_in_ready", in_ready, 0);

    n = 0;
    while (stage_en && n < 100) begin
      in_valid = (n == 5);
      #1;
      chk("filt_stage_sel", stage_sel, n % ST);
      chk("filt_addra", addra, n / ST);
      chk("filt_wr_en", wr_en, 0);
      if (n >= 6) chk("filt_overrun", overrun, 1);
      n++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("filt_cycles", n, FL * ST);
    chk("fetch_rd_valid", rd_valid, 1);
    chk("fetch_rd_addr0", rd_addr, 0);
    chk("fetch_stage_en", stage_en, 0);

    hs = 0;
    n = 0;
    while (rd_valid && n < 100) begin
      rd_ready = (n % 2 == 0);
      start    = (n == 1);
      #1;
      chk("fetch_rd_addr", rd_addr, hs);
      chk("fetch_overrun", overrun, 1);
      if (rd_ready) hs++;
      n++;
      tick();
    end
    rd_ready = 1'b0;
    start    = 1'b0;
    #1;
    chk("fetch_handshakes", hs, FL);
    chk("fetch_cycles", n, 2 * FL - 1);
    chk("done_pulse", frame_done, 1);
    chk("done_busy", busy, 1);
    chk("done_overrun", overrun, 1);
    tick();
    chk("done_one_cycle", frame_done, 0);
`ifdef ECG_SCHED_CONTINUOUS_EN
    chk("cont_in_ready", in_ready, 1);
    chk("cont_addra", addra, 0);
    chk("cont_busy", busy, 1);
`else
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_overrun_held", overrun, 1);
    tick();
    chk("idle_no_autostart", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("start2_in_ready", in_ready, 1);
    chk("start2_overrun_clr", overrun, 0);
`endif

    // Frame 2: abort with reset partway through FILT.
    load_frame();
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("pre_rst_stage_en", stage_en, 1);
    chk("pre_rst_overrun", overrun, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_addra", addra, 0);
    chk("midrst_stage_sel", stage_sel, 0);
    chk("midrst_strobes", {in_ready, stage_en, rd_valid, frame_done, wr_en}, 0);
    chk("midrst_overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
